// File: rtl/sr_cmd_gen_if.sv
// sr_cmd_gen_if: button inputs and command outputs of sr_cmd_gen.
//   set_btn, clr_btn : raw asynchronous push-buttons (may bounce)
//   s, r             : one-cycle set / reset pulses for sr_ff
//   conflict         : one-cycle pulse when both commands collide
//   cmd_count        : issued s + r pulses, modulo 256
// master = button/stimulus side, slave = sr_cmd_gen.
interface sr_cmd_gen_if;
  logic       set_btn;
  logic       clr_btn;
  logic       s;
  logic       r;
  logic       conflict;
  logic [7:0] cmd_count;

  modport master (output set_btn, clr_btn, input s, r, conflict, cmd_count);
  modport slave  (input set_btn, clr_btn, output s, r, conflict, cmd_count);
endinterface

// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: command stage in front of sr_ff. Each button is synchronised
// (2 flops), debounced (DB_CYCLES consecutive differing samples), and
// rising-edge detected. A registered arbiter turns the edges into s / r
// pulses, never both; a same-cycle collision gives a conflict pulse only.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears all state
//   bus   : sr_cmd_gen_if.slave (buttons in, s/r/conflict/cmd_count out)
module sr_cmd_gen #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 3
) (
  input  logic         clk,
  input  logic         reset,
  sr_cmd_gen_if.slave  bus
);
  localparam int                 NUM_CH  = 2;  // lane 0 = set, lane 1 = clear
  localparam logic [CNT_W-1:0]   DB_LAST = CNT_W'(DB_CYCLES - 1);

  logic [NUM_CH-1:0]            btn;
  logic [NUM_CH-1:0][1:0]       sync_q;       // [0] = syncA, [1] = syncB
  logic [NUM_CH-1:0]            stable_q, stable_d;
  logic [NUM_CH-1:0]            stable_dly_q;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]            req;

  logic       s_q, s_d;
  logic       r_q, r_d;
  logic       conf_q, conf_d;
  logic [7:0] cmd_cnt_q, cmd_cnt_d;

  assign btn = {bus.clr_btn, bus.set_btn};

  // Debounce: a sample equal to stable restarts the count, so only an
  // uninterrupted run of DB_CYCLES differing samples flips stable.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sync_q[c][1] != stable_q[c]) begin
        if (cnt_q[c] == DB_LAST) stable_d[c] = sync_q[c][1];
        else                     cnt_d[c]    = cnt_q[c] + 1'b1;
      end
    end
  end

  // Press edges only; releases produce nothing.
  assign req = stable_q & ~stable_dly_q;

  // Arbitration: a collision drops both commands and is not retried.
  always_comb begin
    s_d       = req[0] & ~req[1];
    r_d       = req[1] & ~req[0];
    conf_d    = req[0] &  req[1];
    cmd_cnt_d = cmd_cnt_q;
    if (s_d | r_d) cmd_cnt_d = cmd_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q       <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      cnt_q        <= '0;
      s_q          <= 1'b0;
      r_q          <= 1'b0;
      conf_q       <= 1'b0;
      cmd_cnt_q    <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) sync_q[c] <= {sync_q[c][0], btn[c]};
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
      s_q          <= s_d;
      r_q          <= r_d;
      conf_q       <= conf_d;
      cmd_cnt_q    <= cmd_cnt_d;
    end
  end

  assign bus.s         = s_q;
  assign bus.r         = r_q;
  assign bus.conflict  = conf_q;
  assign bus.cmd_count = cmd_cnt_q;
endmodule
